// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the MEM->WB pipeline register.
//   RstEnable    : level of the active-low reset when asserted
//   STOP/NOSTOP  : values of the per-stage stall vector bits
//   WriteEnable/WriteDisable, ZeroWord, NOPRegAddr : idle values of the stage
//   stage_act_e  : action chosen for the stage on each clock edge
package mem_wb_stage_pkg;

  localparam logic        RstEnable    = 1'b0;
  localparam logic        STOP         = 1'b1;
  localparam logic        NOSTOP       = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;

  typedef enum logic [1:0] {
    ADVANCE = 2'd0,
    HOLD    = 2'd1,
    BUBBLE  = 2'd2
  } stage_act_e;

endpackage

// File: rtl/mem_wb_stage_sat_counter.sv
// Saturating up-counter used for the stage performance counters.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears q
//   clr : synchronous clear, overrides inc
//   inc : increment request; ignored once q is all-ones
//   q   : counter value
module sat_counter
  import mem_wb_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable)     q <= '0;
    else if (clr)             q <= '0;
    else if (inc && ~&q)      q <= q + 1'b1;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with NUM_CH register-write channels plus a HI/LO write.
// Applies flush / stall-bubble / hold rules, drops writes to register 0, resolves
// same-address writes in favour of the highest channel, and keeps saturating
// retire / bubble / hold counters.
//   clk, rst (async active-low), stall[STALL_W], flush, cnt_clr
//   mem_* : MEM-stage results (valid, wd, wreg, wdata, whilo, hi, lo)
//   wb_*  : registered copies feeding the regfile, HI/LO and forwarding path
//   retire_cnt, bubble_cnt, hold_cnt : perf counters
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_CH  = 2,
  parameter int STALL_W = 6,
  parameter int UP_IDX  = 4,
  parameter int DN_IDX  = 5,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic                     cnt_clr,
  input  logic                     mem_valid,
  input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
  input  logic [NUM_CH-1:0]        mem_wreg,
  input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
  input  logic                     mem_whilo,
  input  logic [DATA_W-1:0]        mem_hi,
  input  logic [DATA_W-1:0]        mem_lo,
  output logic                     wb_valid,
  output logic [NUM_CH*ADDR_W-1:0] wb_wd,
  output logic [NUM_CH-1:0]        wb_wreg,
  output logic [NUM_CH*DATA_W-1:0] wb_wdata,
  output logic                     wb_whilo,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         hold_cnt
);

  stage_act_e         act;
  logic [NUM_CH-1:0]  en_nz;     // enabled, valid, and not targeting register 0
  logic [NUM_CH-1:0]  wreg_arb;  // after same-address arbitration

  // Flush beats every stall pattern; a stalled MEM with a running WB must
  // inject a bubble so WB does not re-commit the stale instruction.
  always_comb begin
    act = ADVANCE;
    if (flush)                                             act = BUBBLE;
    else if (stall[UP_IDX] == STOP && stall[DN_IDX] == NOSTOP) act = BUBBLE;
    else if (stall[UP_IDX] == STOP && stall[DN_IDX] == STOP)   act = HOLD;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic kill;

    assign en_nz[i] = mem_valid & mem_wreg[i]
                    & (mem_wd[i*ADDR_W +: ADDR_W] != NOPRegAddr[ADDR_W-1:0]);

    // A later channel writing the same register supersedes this one.
    always_comb begin
      kill = 1'b0;
      for (int j = i + 1; j < NUM_CH; j++)
        if (en_nz[j] && mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])
          kill = 1'b1;
    end

    assign wreg_arb[i] = en_nz[i] & ~kill;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wb_valid <= 1'b0;
      wb_wd    <= '0;
      wb_wreg  <= '0;
      wb_wdata <= '0;
      wb_whilo <= WriteDisable;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else begin
      case (act)
        BUBBLE: begin
          wb_valid <= 1'b0;
          wb_wd    <= '0;
          wb_wreg  <= '0;
          wb_wdata <= '0;
          wb_whilo <= WriteDisable;
          wb_hi    <= '0;
          wb_lo    <= '0;
        end
        ADVANCE: begin
          wb_valid <= mem_valid;
          wb_wd    <= mem_wd;
          wb_wreg  <= wreg_arb;
          wb_wdata <= mem_wdata;
          wb_whilo <= mem_valid ? mem_whilo : WriteDisable;
          wb_hi    <= mem_hi;
          wb_lo    <= mem_lo;
        end
        default: ;  // HOLD keeps everything
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_retire (
    .clk(clk), .rst(rst), .clr(cnt_clr),
    .inc(act == ADVANCE && mem_valid), .q(retire_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .clk(clk), .rst(rst), .clr(cnt_clr),
    .inc(act == BUBBLE), .q(bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hold (
    .clk(clk), .rst(rst), .clr(cnt_clr),
    .inc(act == HOLD), .q(hold_cnt)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam int DATA_W = 32, ADDR_W = 5, NUM_CH = 2, STALL_W = 6, CNT_W = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [STALL_W-1:0]       stall;
  logic                     flush, cnt_clr, mem_valid, mem_whilo;
  logic [NUM_CH*ADDR_W-1:0] mem_wd;
  logic [NUM_CH-1:0]        mem_wreg;
  logic [NUM_CH*DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0]        mem_hi, mem_lo;
  logic                     wb_valid, wb_whilo;
  logic [NUM_CH*ADDR_W-1:0] wb_wd;
  logic [NUM_CH-1:0]        wb_wreg;
  logic [NUM_CH*DATA_W-1:0] wb_wdata;
  logic [DATA_W-1:0]        wb_hi, wb_lo;
  logic [CNT_W-1:0]         retire_cnt, bubble_cnt, hold_cnt;

  int checks = 0;
  int failures = 0;

  mem_wb_stage #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .STALL_W(STALL_W),
    .UP_IDX(4), .DN_IDX(5), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] wd, input logic [1:0] we,
                       input logic [63:0] wdata);
    mem_valid = v; mem_wd = wd; mem_wreg = we; mem_wdata = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_wd !== '0 || wb_wreg !== '0 || wb_wdata !== '0 ||
        wb_whilo !== 1'b0 || wb_hi !== '0 || wb_lo !== '0) begin
      failures++;
      $display("FAIL reset_initial: valid=%b wd=%h wreg=%b wdata=%h expected all 0",
               wb_valid, wb_wd, wb_wreg, wb_wdata);
    end
    rst = 1'b1;
    drive(1'b1, {5'd0, 5'd9}, 2'b01, {32'h0, 32'hDEAD_BEEF});
    tick();
    checks++;
    if (wb_wdata[31:0] !== 32'hDEAD_BEEF || retire_cnt !== 4'd1) begin
      failures++;
      $display("FAIL reset_preload: wdata=%h retire=%0d expected deadbeef 1",
               wb_wdata[31:0], retire_cnt);
    end
    // Assert reset away from any edge: outputs must clear without waiting for clk.
    #2 rst = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_wdata !== '0 || wb_wd !== '0 || wb_wreg !== '0 ||
        retire_cnt !== '0 || bubble_cnt !== '0 || hold_cnt !== '0) begin
      failures++;
      $display("FAIL reset_async: valid=%b wdata=%h wd=%h retire=%0d expected all 0",
               wb_valid, wb_wdata, wb_wd, retire_cnt);
    end
    drive(1'b0, '0, '0, '0);
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_advance();
    drive(1'b1, {5'd0, 5'd3}, 2'b01, {32'h0, 32'h1234_5678});
    mem_whilo = 1'b1; mem_hi = 32'hAAAA_0001; mem_lo = 32'hBBBB_0002;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_wd[4:0] !== 5'd3 || wb_wdata[31:0] !== 32'h1234_5678 ||
        wb_wreg !== 2'b01 || retire_cnt !== 4'd1) begin
      failures++;
      $display("FAIL advance: valid=%b wd=%0d wdata=%h wreg=%b retire=%0d expected 1 3 12345678 01 1",
               wb_valid, wb_wd[4:0], wb_wdata[31:0], wb_wreg, retire_cnt);
    end
    checks++;
    if (wb_whilo !== 1'b1 || wb_hi !== 32'hAAAA_0001 || wb_lo !== 32'hBBBB_0002) begin
      failures++;
      $display("FAIL advance_hilo: whilo=%b hi=%h lo=%h expected 1 aaaa0001 bbbb0002",
               wb_whilo, wb_hi, wb_lo);
    end
    mem_whilo = 1'b0;
  endtask

  task automatic test_stall();
    stall = 6'b011111;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_wreg !== '0 || wb_wdata !== '0 || wb_hi !== '0 ||
        bubble_cnt !== 4'd1 || retire_cnt !== 4'd1) begin
      failures++;
      $display("FAIL stall_bubble: valid=%b wreg=%b wdata=%h bubble=%0d retire=%0d expected 0 00 0 1 1",
               wb_valid, wb_wreg, wb_wdata, bubble_cnt, retire_cnt);
    end
    // Load a recognisable value so the hold below has something to freeze.
    stall = '0;
    drive(1'b1, {5'd0, 5'd12}, 2'b01, {32'h0, 32'h0000_55AA});
    tick();
    stall = 6'b111111;
    drive(1'b1, {5'd20, 5'd21}, 2'b11, {32'hFFFF_0000, 32'h0BAD_F00D});
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (wb_wdata[31:0] !== 32'h0000_55AA || wb_wd[4:0] !== 5'd12 || wb_wreg !== 2'b01 ||
          wb_valid !== 1'b1 || hold_cnt !== k[3:0]) begin
        failures++;
        $display("FAIL stall_hold_%0d: wdata=%h wd=%0d wreg=%b hold=%0d expected 55aa 12 01 %0d",
                 k, wb_wdata[31:0], wb_wd[4:0], wb_wreg, hold_cnt, k);
      end
    end
    checks++;
    if (retire_cnt !== 4'd2 || bubble_cnt !== 4'd1) begin
      failures++;
      $display("FAIL stall_counts: retire=%0d bubble=%0d expected 2 1", retire_cnt, bubble_cnt);
    end
    stall = '0;
  endtask

  task automatic test_arbitration();
    drive(1'b1, {5'd7, 5'd7}, 2'b11, {32'h2222_2222, 32'h1111_1111});
    tick();
    checks++;
    if (wb_wreg !== 2'b10 || wb_wdata !== {32'h2222_2222, 32'h1111_1111}) begin
      failures++;
      $display("FAIL arb_same_addr: wreg=%b wdata=%h expected 10 2222222211111111",
               wb_wreg, wb_wdata);
    end
    drive(1'b1, {5'd0, 5'd0}, 2'b11, {32'h4444_4444, 32'h3333_3333});
    tick();
    checks++;
    if (wb_wreg !== 2'b00 || wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL arb_zero_reg: wreg=%b valid=%b expected 00 1", wb_wreg, wb_valid);
    end
    drive(1'b1, {5'd8, 5'd6}, 2'b11, {32'h6, 32'h5});
    tick();
    checks++;
    if (wb_wreg !== 2'b11 || wb_wd !== {5'd8, 5'd6}) begin
      failures++;
      $display("FAIL arb_diff_addr: wreg=%b wd=%h expected 11 106", wb_wreg, wb_wd);
    end
    drive(1'b0, {5'd8, 5'd6}, 2'b11, {32'h6, 32'h5});
    tick();
    checks++;
    if (wb_wreg !== 2'b00 || wb_valid !== 1'b0 || retire_cnt !== 4'd5) begin
      failures++;
      $display("FAIL arb_invalid: wreg=%b valid=%b retire=%0d expected 00 0 5",
               wb_wreg, wb_valid, retire_cnt);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, {5'd0, 5'd4}, 2'b01, {32'h0, 32'hCAFE_0001});
    tick();
    stall = 6'b111111;
    flush = 1'b1;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_wreg !== '0 || wb_wdata !== '0 ||
        bubble_cnt !== 4'd2 || hold_cnt !== 4'd3 || retire_cnt !== 4'd6) begin
      failures++;
      $display("FAIL flush_priority: valid=%b wdata=%h bubble=%0d hold=%0d retire=%0d expected 0 0 2 3 6",
               wb_valid, wb_wdata, bubble_cnt, hold_cnt, retire_cnt);
    end
    flush = 1'b0;
    stall = '0;
  endtask

  task automatic test_counters();
    drive(1'b0, '0, '0, '0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (retire_cnt !== '0 || bubble_cnt !== '0 || hold_cnt !== '0) begin
      failures++;
      $display("FAIL cnt_clear: retire=%0d bubble=%0d hold=%0d expected 0 0 0",
               retire_cnt, bubble_cnt, hold_cnt);
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, {5'd0, 5'd1}, 2'b01, {32'h0, 32'(k)});
      tick();
    end
    checks++;
    if (retire_cnt !== 4'hF || bubble_cnt !== '0) begin
      failures++;
      $display("FAIL cnt_saturate: retire=%h bubble=%0d expected f 0", retire_cnt, bubble_cnt);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (retire_cnt !== '0 || wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL cnt_clr_override: retire=%0d valid=%b expected 0 1", retire_cnt, wb_valid);
    end
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; cnt_clr = 1'b0;
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
    drive(1'b0, '0, '0, '0);
    test_reset();
    test_advance();
    test_stall();
    test_arbitration();
    test_flush();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
